cursor_controller: RTL
======================

CURSOR_CONTROLLER -- requirements
Module: cursor_controller

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; every register updates on its rising edge.
REQ-002 SHALL have port RESET, input, 1; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port BTN_UP / BTN_DOWN / BTN_LEFT / BTN_RIGHT / BTN_CENTER, input, 1 each; debounced button levels.
REQ-004 SHALL have port BOARD, input, 256; square n is BOARD[4n+3:4n], with bit 3 the colour (0 white, 1 black) and bits 2:0 the piece (0 none).
REQ-005 SHALL have port MOVE_READY, input, 1; the consumer accepts the current move request.
REQ-006 SHALL have port MOVE_OK, input, 1; legality verdict, sampled with MOVE_READY.
REQ-007 SHALL have port CURSOR_ADDR, output, 6; {row,col} of the cursor, row 0 at the top.
REQ-008 SHALL have port SELECT_ADDR, output, 6, and port SELECT_EN, output, 1; the selected square and its valid flag.
REQ-009 SHALL have port MOVE_VALID, output, 1, plus MOVE_FROM and MOVE_TO, output, 6 each; the move request.
REQ-010 SHALL have port TURN, output, 1; side to move (0 white).

Function
REQ-011 SHALL register each button once and act only on a rising edge (previous 0, current 1).
- At most one action per cycle.
- Priority: CENTER > UP > DOWN > LEFT > RIGHT.
- Lower-priority edges in that cycle are discarded.
REQ-012 Cursor moves SHALL take effect the cycle after the edge:
- UP: row-1. DOWN: row+1. LEFT: col-1. RIGHT: col+1.
- Edge behaviour per REQ-024.
REQ-013 SHALL implement states IDLE, PICKED, REQ, all registered.
REQ-014 IDLE, CENTER edge:
- If BOARD[CURSOR_ADDR] piece!=0 and colour==TURN: SELECT_ADDR<=CURSOR_ADDR, SELECT_EN<=1, go to PICKED.
- Otherwise: no change.
REQ-015 PICKED, CENTER edge with CURSOR_ADDR==SELECT_ADDR: SELECT_EN<=0, go to IDLE.
REQ-016 PICKED, CENTER edge on another own-colour occupied square: SELECT_ADDR<=CURSOR_ADDR, stay in PICKED.
REQ-017 PICKED, CENTER edge on any other square:
- MOVE_FROM<=SELECT_ADDR, MOVE_TO<=CURSOR_ADDR, MOVE_VALID<=1, go to REQ.
- Latency: 1 cycle from the registered edge.
REQ-018 REQ handshake:
- MOVE_VALID, MOVE_FROM and MOVE_TO SHALL hold stable until a cycle with MOVE_READY=1.
- In that cycle: MOVE_VALID<=0 next cycle.
- If MOVE_OK=1: TURN toggles, SELECT_EN<=0, go to IDLE.
- If MOVE_OK=0: SELECT_EN stays 1, go to PICKED.
REQ-019 In REQ, all button edges SHALL be discarded and the cursor SHALL not move.
REQ-020 MOVE_READY outside REQ SHALL be ignored; MOVE_VALID never asserts outside REQ.
REQ-021 BOARD SHALL be sampled combinationally only in the CENTER-edge cycle; no copy is stored.

Reset
REQ-022 While RESET=0, outputs SHALL asynchronously take these values:
- CURSOR_ADDR=6'd52 (row 6, col 4); SELECT_ADDR=0; SELECT_EN=0.
- MOVE_VALID=0; MOVE_FROM=0; MOVE_TO=0; TURN=0; state IDLE.
- Button history registers=1, so buttons held through reset produce no edge.
REQ-023 A reset asserted during REQ SHALL drop MOVE_VALID immediately without waiting for MOVE_READY.

Configuration
REQ-024 Macro CURSOR_WRAP_EN:
- Defined: cursor moves wrap modulo 8 per axis (col 7 RIGHT -> col 0; row 0 UP -> row 7).
- Undefined: cursor moves saturate at 0 and 7, with no change at the edge.

Verification
REQ-025 Reset with BTN_UP held high, then release RESET -> CURSOR_ADDR=52, no movement, TURN=0, SELECT_EN=0.
REQ-026 From 52, press RIGHT 3 times -> CURSOR_ADDR=55. Then one more RIGHT -> 48 with CURSOR_WRAP_EN defined, 55 without it.
REQ-027 BOARD square 52=4'b0001; CENTER -> SELECT_EN=1, SELECT_ADDR=52. Then UP x2 and CENTER -> MOVE_VALID=1, MOVE_FROM=52, MOVE_TO=36.
REQ-028 Hold MOVE_READY=0 for 5 cycles -> outputs stable. Then MOVE_READY=1 with MOVE_OK=1 -> MOVE_VALID=0, TURN=1, SELECT_EN=0, state IDLE.
REQ-029 Repeat with MOVE_OK=0 -> TURN=0, SELECT_EN=1, SELECT_ADDR=52. Then CENTER on 52 -> SELECT_EN=0.
REQ-030 Other checks:
- CENTER on an empty square or a black piece while TURN=0 -> no change.
- CENTER and LEFT rising in the same cycle -> only CENTER acts.

Source files
------------

// File: rtl/cursor_controller.sv
// Chess-board cursor, piece selection and move-request handshake.
// Optional build macro CURSOR_WRAP_EN: cursor wraps modulo 8 per axis instead of saturating.
module cursor_controller (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         BTN_UP,
    input  logic         BTN_DOWN,
    input  logic         BTN_LEFT,
    input  logic         BTN_RIGHT,
    input  logic         BTN_CENTER,
    input  logic [255:0] BOARD,
    input  logic         MOVE_READY,
    input  logic         MOVE_OK,
    output logic [5:0]   CURSOR_ADDR,
    output logic [5:0]   SELECT_ADDR,
    output logic         SELECT_EN,
    output logic         MOVE_VALID,
    output logic [5:0]   MOVE_FROM,
    output logic [5:0]   MOVE_TO,
    output logic         TURN
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PICKED = 2'd1,
        ST_REQ    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  btn_prev_q, btn_prev_d;
    logic [2:0]  row_q, row_d;
    logic [2:0]  col_q, col_d;
    logic [5:0]  sel_addr_q, sel_addr_d;
    logic        sel_en_q, sel_en_d;
    logic        move_valid_q, move_valid_d;
    logic [5:0]  move_from_q, move_from_d;
    logic [5:0]  move_to_q, move_to_d;
    logic        turn_q, turn_d;

    logic [4:0]  btn_s;
    logic [4:0]  btn_edge_s;
    logic [5:0]  cursor_s;
    logic [3:0]  square_s;
    logic        own_piece_s;

    function automatic logic [2:0] dec3(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
        dec3 = v - 3'd1;
`else
        dec3 = (v == 3'd0) ? v : v - 3'd1;
`endif
    endfunction

    function automatic logic [2:0] inc3(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
        inc3 = v + 3'd1;
`else
        inc3 = (v == 3'd7) ? v : v + 3'd1;
`endif
    endfunction

    // Bit order encodes action priority: CENTER, UP, DOWN, LEFT, RIGHT.
    assign btn_s       = {BTN_CENTER, BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT};
    assign btn_edge_s  = btn_s & ~btn_prev_q;
    assign cursor_s    = {row_q, col_q};
    assign square_s    = BOARD[{cursor_s, 2'b00} +: 4];
    assign own_piece_s = (square_s[2:0] != 3'd0) && (square_s[3] == turn_q);

    // Next-state and next-output logic for cursor, selection and handshake.
    always_comb begin
        state_d      = state_q;
        btn_prev_d   = btn_s;
        row_d        = row_q;
        col_d        = col_q;
        sel_addr_d   = sel_addr_q;
        sel_en_d     = sel_en_q;
        move_valid_d = move_valid_q;
        move_from_d  = move_from_q;
        move_to_d    = move_to_q;
        turn_d       = turn_q;
        case (state_q)
            ST_REQ: begin
                if (MOVE_READY) begin
                    move_valid_d = 1'b0;
                    if (MOVE_OK) begin
                        turn_d   = ~turn_q;
                        sel_en_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_PICKED;
                    end
                end else begin
                    move_valid_d = 1'b1;
                end
            end
            ST_IDLE, ST_PICKED: begin
                if (btn_edge_s[4]) begin
                    if (state_q == ST_IDLE) begin
                        if (own_piece_s) begin
                            sel_addr_d = cursor_s;
                            sel_en_d   = 1'b1;
                            state_d    = ST_PICKED;
                        end else begin
                            state_d    = ST_IDLE;
                        end
                    end else if (cursor_s == sel_addr_q) begin
                        sel_en_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else if (own_piece_s) begin
                        sel_addr_d = cursor_s;
                    end else begin
                        move_from_d  = sel_addr_q;
                        move_to_d    = cursor_s;
                        move_valid_d = 1'b1;
                        state_d      = ST_REQ;
                    end
                end else if (btn_edge_s[3]) begin
                    row_d = dec3(row_q);
                end else if (btn_edge_s[2]) begin
                    row_d = inc3(row_q);
                end else if (btn_edge_s[1]) begin
                    col_d = dec3(col_q);
                end else if (btn_edge_s[0]) begin
                    col_d = inc3(col_q);
                end else begin
                    row_d = row_q;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                sel_en_d     = 1'b0;
                move_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; button history resets high so held buttons give no edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            btn_prev_q   <= 5'b11111;
            row_q        <= 3'd6;
            col_q        <= 3'd4;
            sel_addr_q   <= 6'd0;
            sel_en_q     <= 1'b0;
            move_valid_q <= 1'b0;
            move_from_q  <= 6'd0;
            move_to_q    <= 6'd0;
            turn_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_prev_q   <= btn_prev_d;
            row_q        <= row_d;
            col_q        <= col_d;
            sel_addr_q   <= sel_addr_d;
            sel_en_q     <= sel_en_d;
            move_valid_q <= move_valid_d;
            move_from_q  <= move_from_d;
            move_to_q    <= move_to_d;
            turn_q       <= turn_d;
        end
    end

    assign CURSOR_ADDR = cursor_s;
    assign SELECT_ADDR = sel_addr_q;
    assign SELECT_EN   = sel_en_q;
    assign MOVE_VALID  = move_valid_q;
    assign MOVE_FROM   = move_from_q;
    assign MOVE_TO     = move_to_q;
    assign TURN        = turn_q;

endmodule
